// File: rtl/asym_fifo_w1_r2.sv
// Single-clock FIFO: 1-bit serial writes, 2-bit word reads (first-written bit in DOUT[0]).
// Read data registered on the accepting edge; FULL/EMPTY reject and set sticky OVF/UDF.
module asym_fifo_w1_r2 #(
   parameter int ADDR_W = 12
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              FLUSH,
   input  logic              WR_EN,
   input  logic              DIN,
   output logic              FULL,
   input  logic              RD_EN,
   output logic [1:0]        DOUT,
   output logic              DOUT_VALID,
   output logic              EMPTY,
   output logic [ADDR_W:0]   COUNT,
   output logic              OVF,
   output logic              UDF
);

   localparam logic [ADDR_W:0] CAP = {1'b1, {ADDR_W{1'b0}}};

   logic                mem_q [2**ADDR_W];
   logic [ADDR_W-1:0]   wp_q, wp_d;
   logic [ADDR_W-2:0]   rp_q, rp_d;
   logic [ADDR_W:0]     count_q, count_d;
   logic [1:0]          dout_q, dout_d;
   logic                dout_valid_q, dout_valid_d;
   logic                ovf_q, ovf_d;
   logic                udf_q, udf_d;
   logic                full, empty, wa, ra;

   always_comb begin
      full         = (count_q == CAP);
      empty        = (count_q[ADDR_W:1] == '0);
      wa           = WR_EN & ~full & ~FLUSH;
      ra           = RD_EN & ~empty & ~FLUSH;
      wp_d         = wp_q;
      rp_d         = rp_q;
      count_d      = count_q;
      dout_d       = dout_q;
      dout_valid_d = 1'b0;
      ovf_d        = ovf_q;
      udf_d        = udf_q;
      if (FLUSH) begin
         wp_d    = '0;
         rp_d    = '0;
         count_d = '0;
         ovf_d   = 1'b0;
         udf_d   = 1'b0;
      end else begin
         if (wa) wp_d = wp_q + ADDR_W'(1);
         if (ra) begin
            rp_d         = rp_q + (ADDR_W-1)'(1);
            dout_d       = {mem_q[{rp_q, 1'b1}], mem_q[{rp_q, 1'b0}]};
            dout_valid_d = 1'b1;
         end
         case ({wa, ra})
            2'b10:   count_d = count_q + (ADDR_W+1)'(1);
            2'b01:   count_d = count_q - (ADDR_W+1)'(2);
            2'b11:   count_d = count_q - (ADDR_W+1)'(1);
            default: count_d = count_q;
         endcase
         ovf_d = ovf_q | (WR_EN & full);
         udf_d = udf_q | (RD_EN & empty);
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         wp_q         <= '0;
         rp_q         <= '0;
         count_q      <= '0;
         dout_q       <= 2'b00;
         dout_valid_q <= 1'b0;
         ovf_q        <= 1'b0;
         udf_q        <= 1'b0;
      end else begin
         wp_q         <= wp_d;
         rp_q         <= rp_d;
         count_q      <= count_d;
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
         ovf_q        <= ovf_d;
         udf_q        <= udf_d;
      end
   end

   // Storage survives reset; only the write itself is blocked while reset is held.
   always_ff @(posedge CLK) begin
      if (RST_N && wa) mem_q[wp_q] <= DIN;
   end

   assign FULL       = full;
   assign EMPTY      = empty;
   assign COUNT      = count_q;
   assign DOUT       = dout_q;
   assign DOUT_VALID = dout_valid_q;
   assign OVF        = ovf_q;
   assign UDF        = udf_q;

endmodule
